// File: rtl/cpu_stack.sv
// Architectural operand stack fed by the stage-5 commit bundle; pop-then-push each cycle.
// Optional high-water-mark output st__hwm is built when CPU_STACK_HWM_EN is defined.
module cpu_stack #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned ENTRY_W = 35
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               st__push_5a,
    input  logic [10:0]        st__to_pop_5a,
    input  logic [ENTRY_W-1:0] st__to_push_5a,
    input  logic               st__err_clr,
    output logic [ENTRY_W-1:0] st__tos0,
    output logic [ENTRY_W-1:0] st__tos1,
    output logic [ADDR_W:0]    st__depth,
    output logic               st__ovf,
    output logic               st__unf
`ifdef CPU_STACK_HWM_EN
    ,
    output logic [ADDR_W:0]    st__hwm
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned DW    = ADDR_W + 1;
    // Pop comparison is done at full pop width so large pop counts never alias.
    localparam int unsigned CW    = (ADDR_W + 2 > 11) ? ADDR_W + 2 : 11;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]    r_depth;
    logic [ENTRY_W-1:0] r_tos0;
    logic [ENTRY_W-1:0] r_tos1;
    logic               r_ovf;
    logic               r_unf;

    logic [CW-1:0]      w_pop_ext;
    logic [CW-1:0]      w_depth_ext;
    logic               w_unf_evt;
    logic [ADDR_W:0]    w_d1;
    logic               w_full;
    logic               w_ovf_evt;
    logic               w_wr;
    logic [ADDR_W:0]    w_nd;
    logic [ADDR_W-1:0]  w_idx0;
    logic [ADDR_W-1:0]  w_idx1;
    logic [ENTRY_W-1:0] w_tos0_d;
    logic [ENTRY_W-1:0] w_tos1_d;

    always_comb begin
        w_pop_ext   = CW'(st__to_pop_5a);
        w_depth_ext = CW'(r_depth);
        w_unf_evt   = w_pop_ext > w_depth_ext;
        w_d1        = w_unf_evt ? '0 : (r_depth - DW'(w_pop_ext));

        w_full      = (w_d1 == DW'(DEPTH));
        w_ovf_evt   = st__push_5a && w_full;
        w_wr        = st__push_5a && !w_full;
        w_nd        = w_wr ? (w_d1 + DW'(1)) : w_d1;

        w_idx0      = ADDR_W'(w_nd - DW'(1));
        w_idx1      = ADDR_W'(w_nd - DW'(2));

        // A fresh push always lands at nd-1, so forward it instead of reading storage.
        w_tos0_d    = '0;
        if (w_nd != '0) begin
            w_tos0_d = w_wr ? st__to_push_5a : r_mem[w_idx0];
        end
        w_tos1_d    = '0;
        if (w_nd >= DW'(2)) begin
            w_tos1_d = r_mem[w_idx1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_d1[ADDR_W-1:0]] <= st__to_push_5a;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_depth <= '0;
            r_tos0  <= '0;
            r_tos1  <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_depth <= w_nd;
            r_tos0  <= w_tos0_d;
            r_tos1  <= w_tos1_d;
            // A new error event wins over a simultaneous clear.
            r_ovf   <= w_ovf_evt | (r_ovf & ~st__err_clr);
            r_unf   <= w_unf_evt | (r_unf & ~st__err_clr);
        end
    end

    assign st__tos0  = r_tos0;
    assign st__tos1  = r_tos1;
    assign st__depth = r_depth;
    assign st__ovf   = r_ovf;
    assign st__unf   = r_unf;

`ifdef CPU_STACK_HWM_EN
    logic [ADDR_W:0] r_hwm;
    logic [ADDR_W:0] w_hwm_d;

    always_comb begin
        w_hwm_d = r_hwm;
        if (st__err_clr) begin
            w_hwm_d = w_nd;
        end else if (w_nd > r_hwm) begin
            w_hwm_d = w_nd;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_hwm <= '0;
        end else begin
            r_hwm <= w_hwm_d;
        end
    end

    assign st__hwm = r_hwm;
`endif

endmodule

// File: tb/tb_cpu_stack.sv
// Scoreboard bench for cpu_stack: stimulus queues expected state, a monitor compares after each edge.
module tb_cpu_stack;

    logic        clk;
    logic        rst_b;
    logic        push;
    logic [10:0] pop;
    logic [34:0] data;
    logic        clr;
    logic [34:0] tos0;
    logic [34:0] tos1;
    logic [5:0]  depth;
    logic        ovf;
    logic        unf;
`ifdef CPU_STACK_HWM_EN
    logic [5:0]  hwm;
`endif

    cpu_stack #(.ADDR_W(5), .ENTRY_W(35)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .st__push_5a    (push),
        .st__to_pop_5a  (pop),
        .st__to_push_5a (data),
        .st__err_clr    (clr),
        .st__tos0       (tos0),
        .st__tos1       (tos1),
        .st__depth      (depth),
        .st__ovf        (ovf),
        .st__unf        (unf)
`ifdef CPU_STACK_HWM_EN
        ,
        .st__hwm        (hwm)
`endif
    );

    typedef struct {
        string       name;
        logic [5:0]  depth;
        logic [34:0] tos0;
        logic [34:0] tos1;
        logic        ovf;
        logic        unf;
        logic [5:0]  hwm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [34:0] dk(input int k);
        return {3'd3, 32'(k)};
    endfunction

    // Drive one commit at the negedge and queue the state expected after the next posedge.
    task automatic cmd(input string nm, input logic p_push, input logic [10:0] p_pop,
                       input logic [34:0] p_data, input logic p_clr,
                       input logic [5:0] e_depth, input logic [34:0] e_tos0,
                       input logic [34:0] e_tos1, input logic e_ovf, input logic e_unf,
                       input logic [5:0] e_hwm);
        exp_t e;
        @(negedge clk);
        push = p_push;
        pop  = p_pop;
        data = p_data;
        clr  = p_clr;
        e.name = nm; e.depth = e_depth; e.tos0 = e_tos0; e.tos1 = e_tos1;
        e.ovf = e_ovf; e.unf = e_unf; e.hwm = e_hwm;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        push = 1'b0;
        pop  = '0;
        data = '0;
        clr  = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".depth"}, 64'(depth), 64'd0);
        chk({nm, ".tos0"}, 64'(tos0), 64'd0);
        chk({nm, ".tos1"}, 64'(tos1), 64'd0);
        chk({nm, ".ovf"}, 64'(ovf), 64'd0);
        chk({nm, ".unf"}, 64'(unf), 64'd0);
`ifdef CPU_STACK_HWM_EN
        chk({nm, ".hwm"}, 64'(hwm), 64'd0);
`endif
    endtask

    // Monitor: outputs are registered, so compare a little after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #3;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".depth"}, 64'(depth), 64'(e.depth));
            chk({e.name, ".tos0"}, 64'(tos0), 64'(e.tos0));
            chk({e.name, ".tos1"}, 64'(tos1), 64'(e.tos1));
            chk({e.name, ".ovf"}, 64'(ovf), 64'(e.ovf));
            chk({e.name, ".unf"}, 64'(unf), 64'(e.unf));
`ifdef CPU_STACK_HWM_EN
            chk({e.name, ".hwm"}, 64'(hwm), 64'(e.hwm));
`endif
        end
    end

    localparam logic [34:0] A1 = 35'h1_00000011;
    localparam logic [34:0] A2 = 35'h1_00000022;
    localparam logic [34:0] A3 = 35'h1_00000033;
    localparam logic [34:0] B  = 35'h2_000000AA;
    localparam logic [34:0] X  = 35'h4_DEADBEEF;
    localparam logic [34:0] E  = 35'h5_12345678;
    localparam logic [34:0] F  = 35'h6_0000F00D;
    localparam logic [34:0] H  = 35'h7_00000077;

    initial begin
        rst_b = 1'b1;
        push  = 1'b0;
        pop   = '0;
        data  = '0;
        clr   = 1'b0;
        #2 rst_b = 1'b0;
        #2 chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;

        cmd("push1", 1, 0, A1, 0, 1, A1, 0, 0, 0, 1);
        cmd("push2", 1, 0, A2, 0, 2, A2, A1, 0, 0, 2);
        cmd("push3", 1, 0, A3, 0, 3, A3, A2, 0, 0, 3);
        cmd("pop2_push", 1, 2, B, 0, 2, B, A1, 0, 0, 3);
        cmd("pop_eq_depth", 0, 2, 0, 0, 0, 0, 0, 0, 0, 3);
        for (int k = 0; k < 32; k++) begin
            cmd($sformatf("fill%0d", k), 1, 0, dk(k), 0, 6'(k + 1), dk(k),
                (k > 0) ? dk(k - 1) : 35'd0, 0, 0, (k + 1 > 3) ? 6'(k + 1) : 6'd3);
        end
        cmd("push_full", 1, 0, X, 0, 32, dk(31), dk(30), 1, 0, 32);
        cmd("pop1_push_full", 1, 1, E, 0, 32, E, dk(30), 1, 0, 32);
        cmd("pop30", 0, 30, 0, 0, 2, dk(1), dk(0), 1, 0, 32);
        cmd("pop5_unf", 0, 5, 0, 0, 0, 0, 0, 1, 1, 32);
        cmd("pop7ff_empty", 0, 11'h7FF, 0, 0, 0, 0, 0, 1, 1, 32);
        cmd("clr_with_unf", 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        cmd("clr_plain", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cmd("push_f", 1, 0, F, 0, 1, F, 0, 0, 0, 1);
        cmd("nop_hold", 0, 0, 0, 0, 1, F, 0, 0, 0, 1);
        cmd("pop_f", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int k = 0; k < 4; k++) begin
            cmd($sformatf("hwm_push%0d", k), 1, 0, dk(16 + k), 0, 6'(k + 1), dk(16 + k),
                (k > 0) ? dk(15 + k) : 35'd0, 0, 0, (k + 1 > 1) ? 6'(k + 1) : 6'd1);
        end
        cmd("hwm_pop3", 0, 3, 0, 0, 1, dk(16), 0, 0, 0, 4);
        cmd("hwm_push", 1, 0, dk(20), 0, 2, dk(20), dk(16), 0, 0, 4);
        cmd("hwm_clr", 0, 0, 0, 1, 2, dk(20), dk(16), 0, 0, 2);

        // Asynchronous reset asserted between clock edges.
        idle();
        #2 rst_b = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst_b = 1'b1;
        cmd("push_after_rst", 1, 0, H, 0, 1, H, 0, 0, 0, 1);
        idle();
        idle();
        idle();
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
